// File: rtl/vga_image_scanner.sv
// Raster engine: VGA timing from a pixel-enable divider, a running image address
// for the memory stage, and a one-tick-delayed grayscale/sync output stage.
module vga_image_scanner #(
    parameter int          H_VIS     = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_VIS     = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter int          IMG_W     = 256,
    parameter int          IMG_H     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CLK_DIV   = 2,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ImageData,
    output logic [31:0] vgaAddress,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        video_on,
    output logic [7:0]  pixel_gray,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int HS_FIRST = H_VIS + H_FP;
    localparam int HS_END   = H_VIS + H_FP + H_SYNC;
    localparam int VS_FIRST = V_VIS + V_FP;
    localparam int VS_END   = V_VIS + V_FP + V_SYNC;

    // ImageData is sampled on the tick, so the memory must answer within one tick.
    if (RD_LAT >= CLK_DIV) begin : g_bad_rd_lat
        $error("vga_image_scanner: RD_LAT must be smaller than CLK_DIV");
    end

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;

    logic tick;
    logic h_last;
    logic v_last;
    logic wrap;
    logic in_img;
    logic next_in_img;
    logic visible;
    logic hs_active;
    logic vs_active;
    logic at_origin;

    assign tick   = (int'(div) == CLK_DIV - 1);
    assign h_last = (int'(h_cnt) == H_TOT - 1);
    assign v_last = (int'(v_cnt) == V_TOT - 1);
    assign wrap   = h_last && v_last;

    always_comb begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_last) begin
            h_next = '0;
            v_next = v_last ? '0 : v_cnt + 1'b1;
        end
    end

    assign in_img      = (int'(h_cnt) < IMG_W) && (int'(v_cnt) < IMG_H);
    // The address steps when the position being entered is an image pixel, so the
    // last pixel of each row (and of the frame) stays on the bus through blanking.
    assign next_in_img = (int'(h_next) < IMG_W) && (int'(v_next) < IMG_H);

    assign visible   = (int'(h_cnt) < H_VIS) && (int'(v_cnt) < V_VIS);
    assign hs_active = (int'(h_cnt) >= HS_FIRST) && (int'(h_cnt) < HS_END);
    assign vs_active = (int'(v_cnt) >= VS_FIRST) && (int'(v_cnt) < VS_END);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge position; the output stage relies on that to lag one tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div         <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            vgaAddress  <= BASE_ADDR;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            video_on    <= 1'b0;
            pixel_gray  <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + 1'b1;
            frame_start <= tick && at_origin;
            if (tick) begin
                h_cnt <= h_next;
                v_cnt <= v_next;

                if (wrap) begin
                    vgaAddress <= BASE_ADDR;
                end else if (next_in_img) begin
                    vgaAddress <= vgaAddress + 32'd1;
                end

                hsync_n    <= !hs_active;
                vsync_n    <= !vs_active;
                video_on   <= visible;
                pixel_gray <= (visible && in_img) ? ImageData : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_vga_image_scanner.sv
// Self-checking bench: reduced raster geometry, random image memory, an arithmetic
// model of the scan derived from elapsed clocks, and random mid-frame resets.
module tb_vga_image_scanner;

    localparam int          H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 3;
    localparam int          V_VIS = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int          IMG_W = 8,  IMG_H = 6;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          CLK_DIV = 2;
    localparam int          H_TOT = H_VIS + H_FP + H_SYNC + H_BP;   // 25
    localparam int          V_TOT = V_VIS + V_FP + V_SYNC + V_BP;   // 19
    localparam int          FRAME = H_TOT * V_TOT;                  // 475 ticks
    localparam int          FRAME_CLK = FRAME * CLK_DIV;            // 950 clk

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ImageData = 8'h00;
    logic [31:0] vgaAddress;
    logic        hsync_n, vsync_n, video_on, frame_start;
    logic [7:0]  pixel_gray;

    logic [7:0]  mem [IMG_W*IMG_H];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 1'b0;

    vga_image_scanner #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BASE_ADDR(BASE),
        .CLK_DIV(CLK_DIV), .RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ImageData(ImageData),
        .vgaAddress(vgaAddress), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .video_on(video_on), .pixel_gray(pixel_gray), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory stage: one registered read, image stored from BASE upward.
    function automatic logic [7:0] mem_rd(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (off < IMG_W * IMG_H) return mem[off];
        return 8'h00;
    endfunction

    always @(posedge clk) ImageData <= mem_rd(vgaAddress);

    // Clock edges since the last edge that sampled rst_n low.
    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            started = 1'b1;
        end else begin
            cyc++;
        end
    end

    // Address presented while the raster sits at frame index idx.
    function automatic logic [31:0] addr_of(input int idx);
        int h, v;
        h = idx % H_TOT;
        v = idx / H_TOT;
        if (v < IMG_H && h < IMG_W) return BASE + 32'(v * IMG_W + h);
        if (v < IMG_H)              return BASE + 32'(v * IMG_W + IMG_W - 1);
        return BASE + 32'(IMG_W * IMG_H - 1);
    endfunction

    always @(negedge clk) begin
        if (started) begin
            int t, p, h, v;
            logic exp_hs, exp_vs, exp_von, exp_fs;
            logic [7:0] exp_gray;
            t = cyc / CLK_DIV;
            check("vgaAddress", vgaAddress, addr_of(t % FRAME));
            if (t == 0) begin
                exp_hs = 1'b1; exp_vs = 1'b1; exp_von = 1'b0; exp_fs = 1'b0; exp_gray = 8'h00;
            end else begin
                p = (t - 1) % FRAME;
                h = p % H_TOT;
                v = p / H_TOT;
                exp_hs   = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                exp_vs   = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                exp_von  = (h < H_VIS) && (v < V_VIS);
                exp_gray = (exp_von && h < IMG_W && v < IMG_H) ? mem_rd(addr_of(p)) : 8'h00;
                exp_fs   = (cyc % CLK_DIV == 0) && (p == 0);
            end
            check("hsync_n", 32'(hsync_n), 32'(exp_hs));
            check("vsync_n", 32'(vsync_n), 32'(exp_vs));
            check("video_on", 32'(video_on), 32'(exp_von));
            check("pixel_gray", 32'(pixel_gray), 32'(exp_gray));
            check("frame_start", 32'(frame_start), 32'(exp_fs));
        end
    end

    // Measures one frame-long window starting at the current negedge.
    task automatic measure_frame(input string tag);
        int hs_low = 0, von_line = 0, vs_low = 0, fs_cnt = 0;
        logic [31:0] max_addr = '0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            @(negedge clk);
            if (i < H_TOT * CLK_DIV) begin
                if (!hsync_n) hs_low++;
                if (video_on) von_line++;
            end
            if (!vsync_n) vs_low++;
            if (frame_start) fs_cnt++;
            if (vgaAddress > max_addr) max_addr = vgaAddress;
        end
        check({tag, " hsync low clk"}, 32'(hs_low), 32'd8);
        check({tag, " video_on clk per line"}, 32'(von_line), 32'd32);
        check({tag, " vsync low clk"}, 32'(vs_low), 32'd100);
        check({tag, " frame_start count"}, 32'(fs_cnt), 32'd1);
        check({tag, " last address"}, max_addr, 32'h0000_012F);
    endtask

    initial begin
        for (int i = 0; i < IMG_W * IMG_H; i++) mem[i] = 8'($urandom_range(1, 255));

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset vgaAddress", vgaAddress, 32'h0000_0100);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset hsync_n", 32'(hsync_n), 32'd1);
        rst_n = 1'b1;

        @(negedge clk);
        check("no advance after 1 clk", vgaAddress, 32'h0000_0100);
        @(negedge clk);
        check("first tick frame_start", 32'(frame_start), 32'd1);
        check("first tick address", vgaAddress, 32'h0000_0101);
        check("first tick pixel", 32'(pixel_gray), 32'(mem[0]));

        // Remainder of frame 1, then a full measured frame.
        repeat (FRAME_CLK - 2) @(negedge clk);
        measure_frame("frame2");

        // Random mid-frame resets around line 4, each followed by a measured frame.
        for (int k = 0; k < 3; k++) begin
            repeat (CLK_DIV * (4 * H_TOT + int'($urandom_range(0, H_TOT - 1))) +
                    int'($urandom_range(0, 1))) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check("mid-frame reset address", vgaAddress, 32'h0000_0100);
            check("mid-frame reset video_on", 32'(video_on), 32'd0);
            rst_n = 1'b1;
            measure_frame("after reset");
        end

        repeat (FRAME_CLK + 7) @(negedge clk);
        started = 1'b0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
